// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: grants, latches operands, returns result.
// Latency: accept edge -> resp_valid two cycles later; one op in flight, issue interval >= 3 cycles.
// Backpressure: result held in RESP until the granted requester's resp_ready; the other sees ready=0.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [3:0]       r0_op,
    output logic             r0_resp_valid,
    output logic [WIDTH-1:0] r0_resp_data,
    input  logic             r0_resp_ready,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [3:0]       r1_op,
    output logic             r1_resp_valid,
    output logic [WIDTH-1:0] r1_resp_data,
    input  logic             r1_resp_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);
    localparam logic [3:0] ALU_XXX = 4'hF;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic             pick_r1;
    logic             accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        a_d           = a_q;
        b_d           = b_q;
        res_d         = res_q;
        op_d          = op_q;
        accept        = 1'b0;
        alu_op        = ALU_XXX;
        r0_resp_valid = 1'b0;
        r1_resp_valid = 1'b0;
        // ptr_q only matters when both requesters contend.
        pick_r1       = r1_valid && (!r0_valid || ptr_q);
        case (state_q)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    accept  = 1'b1;
                    grant_d = pick_r1;
                    a_d     = pick_r1 ? r1_a  : r0_a;
                    b_d     = pick_r1 ? r1_b  : r0_b;
                    op_d    = pick_r1 ? r1_op : r0_op;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_op  = op_q;
                res_d   = alu_out;
                state_d = RESP;
            end
            RESP: begin
                r0_resp_valid = !grant_q;
                r1_resp_valid = grant_q;
                if (grant_q ? r1_resp_ready : r0_resp_ready) begin
                    ptr_d   = !grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign r0_ready     = accept && !pick_r1;
    assign r1_ready     = accept && pick_r1;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign busy         = (state_q != IDLE);
    assign r0_resp_data = grant_q ? '0 : res_q;
    assign r1_resp_data = grant_q ? res_q : '0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the arbiter and a behavioural ALU.
module tb_alu_arbiter;
    localparam logic [3:0] ALU_ADD  = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4, ALU_NOR = 4'h5, ALU_SLL = 4'h6, ALU_SRL = 4'h7;
    localparam logic [3:0] ALU_SRA  = 4'h8, ALU_SLT = 4'h9, ALU_SLTU = 4'hA, ALU_XXX = 4'hF;

    logic        clk, reset_n;
    logic        r0_valid, r0_ready, r0_resp_valid, r0_resp_ready;
    logic        r1_valid, r1_ready, r1_resp_valid, r1_resp_ready;
    logic [31:0] r0_a, r0_b, r0_resp_data, r1_a, r1_b, r1_resp_data;
    logic [3:0]  r0_op, r1_op, alu_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r0_resp_valid(r0_resp_valid), .r0_resp_data(r0_resp_data), .r0_resp_ready(r0_resp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .r1_resp_valid(r1_resp_valid), .r1_resp_data(r1_resp_data), .r1_resp_ready(r1_resp_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .busy(busy)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 executing, 2 responding.
    int          m_phase = 0;
    bit          m_ptr = 0, m_who = 0, choose;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [3:0]  m_op = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_r0_resp_valid", {31'd0, r0_resp_valid}, 0);
            chk("rst_r1_resp_valid", {31'd0, r1_resp_valid}, 0);
            m_phase = 0; m_ptr = 0; m_who = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0;
        end else begin
            choose = (r0_valid && r1_valid) ? m_ptr : r1_valid;
            chk("cmp_busy", {31'd0, busy}, {31'd0, m_phase != 0});
            chk("cmp_r0_ready", {31'd0, r0_ready}, {31'd0, m_phase == 0 && r0_valid && !choose});
            chk("cmp_r1_ready", {31'd0, r1_ready}, {31'd0, m_phase == 0 && r1_valid && choose});
            chk("cmp_alu_a", alu_a, m_a);
            chk("cmp_alu_b", alu_b, m_b);
            chk("cmp_alu_op", {28'd0, alu_op}, {28'd0, (m_phase == 1) ? m_op : ALU_XXX});
            chk("cmp_r0_resp_valid", {31'd0, r0_resp_valid}, {31'd0, m_phase == 2 && !m_who});
            chk("cmp_r1_resp_valid", {31'd0, r1_resp_valid}, {31'd0, m_phase == 2 && m_who});
            if (m_phase == 2) chk("cmp_resp_data", m_who ? r1_resp_data : r0_resp_data, m_res);
            chk("cmp_other_resp_data", m_who ? r0_resp_data : r1_resp_data, 0);
            case (m_phase)
                0: if (r0_valid || r1_valid) begin
                    m_who = choose;
                    m_a = choose ? r1_a : r0_a;
                    m_b = choose ? r1_b : r0_b;
                    m_op = choose ? r1_op : r0_op;
                    m_phase = 1;
                end
                1: begin m_res = alu_f(m_a, m_b, m_op); m_phase = 2; end
                default: if (m_who ? r1_resp_ready : r0_resp_ready) begin
                    m_phase = 0; m_ptr = !m_who; n_done++;
                end
            endcase
        end
    end

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); endtask

    task automatic clear_inputs();
        r0_valid = 0; r0_a = 0; r0_b = 0; r0_op = ALU_ADD; r0_resp_ready = 0;
        r1_valid = 0; r1_a = 0; r1_b = 0; r1_op = ALU_ADD; r1_resp_ready = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        #1;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_op", {28'd0, alu_op}, {28'd0, ALU_XXX});
        chk("reset_r0_resp_data", r0_resp_data, 0);
        nxt(); nxt();
        reset_n = 1;
    endtask

    int gq[$];
    logic [3:0] ops [11];

    initial begin
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
                ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};
        reset_n = 1;
        clear_inputs();
        #2;
        do_reset();

        // Single ADD on r0.
        r0_valid = 1; r0_op = ALU_ADD; r0_a = 5; r0_b = 7; r0_resp_ready = 1; r1_resp_ready = 1;
        mid(); chk("single_r0_ready_c0", {31'd0, r0_ready}, 1);
        nxt(); r0_valid = 0;
        mid(); chk("single_busy_c1", {31'd0, busy}, 1); chk("single_alu_op_c1", {28'd0, alu_op}, {28'd0, ALU_ADD});
        nxt();
        mid(); chk("single_resp_valid_c2", {31'd0, r0_resp_valid}, 1); chk("single_data_c2", r0_resp_data, 12);
        nxt();
        mid(); chk("single_busy_c3", {31'd0, busy}, 0);
        nxt();

        // Contention right after reset: r0 first, r1 held off until IDLE returns.
        do_reset();
        r0_valid = 1; r0_op = ALU_SUB; r0_a = 10; r0_b = 3;
        r1_valid = 1; r1_op = ALU_XOR; r1_a = 32'hF0; r1_b = 32'hFF;
        r0_resp_ready = 1; r1_resp_ready = 1;
        mid(); chk("cont_r0_ready", {31'd0, r0_ready}, 1); chk("cont_r1_ready_c0", {31'd0, r1_ready}, 0);
        nxt(); r0_valid = 0;
        mid(); chk("cont_r1_ready_c1", {31'd0, r1_ready}, 0);
        nxt();
        mid(); chk("cont_r0_data", r0_resp_data, 7); chk("cont_r1_ready_c2", {31'd0, r1_ready}, 0);
        nxt();
        mid(); chk("cont_r1_ready_c3", {31'd0, r1_ready}, 1);
        nxt(); r1_valid = 0;
        nxt();
        mid(); chk("cont_r1_valid", {31'd0, r1_resp_valid}, 1); chk("cont_r1_data", r1_resp_data, 32'h0F);
        nxt();

        // Fairness under continuous contention.
        do_reset();
        r0_valid = 1; r1_valid = 1; r0_resp_ready = 1; r1_resp_ready = 1;
        for (int i = 0; i < 12; i++) begin
            mid();
            if (r0_ready) gq.push_back(0);
            if (r1_ready) gq.push_back(1);
            nxt();
        end
        chk("fair_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("fair_order", gq[i], i % 2);

        // Backpressure on r1 with SLT, then SLTU on the same operands.
        do_reset();
        r1_valid = 1; r1_op = ALU_SLT; r1_a = 32'hFFFF_FFFF; r1_b = 1; r0_resp_ready = 1;
        mid(); chk("bp_r1_ready", {31'd0, r1_ready}, 1);
        nxt(); r1_valid = 0; r0_valid = 1; r0_op = ALU_ADD; r0_a = 2; r0_b = 3;
        mid(); chk("bp_r0_held_exec", {31'd0, r0_ready}, 0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("bp_resp_valid", {31'd0, r1_resp_valid}, 1);
            chk("bp_resp_data", r1_resp_data, 1);
            chk("bp_r0_held", {31'd0, r0_ready}, 0);
            nxt();
        end
        r1_resp_ready = 1;
        mid(); chk("bp_resp_valid_release", {31'd0, r1_resp_valid}, 1);
        nxt();
        mid(); chk("bp_r0_accept", {31'd0, r0_ready}, 1);
        nxt(); r0_valid = 0; r1_valid = 1; r1_op = ALU_SLTU;
        nxt();
        mid(); chk("bp_r0_data", r0_resp_data, 5);
        nxt();
        mid(); chk("bp_sltu_accept", {31'd0, r1_ready}, 1);
        nxt(); r1_valid = 0;
        nxt();
        mid(); chk("bp_sltu_valid", {31'd0, r1_resp_valid}, 1); chk("bp_sltu_data", r1_resp_data, 0);
        nxt();

        // Reset in the middle of an operation.
        do_reset();
        r0_valid = 1; r0_op = ALU_ADD; r0_a = 1; r0_b = 1; r0_resp_ready = 1; r1_resp_ready = 1;
        mid(); chk("mid_r0_ready", {31'd0, r0_ready}, 1);
        nxt(); r0_valid = 0;
        #1; chk("mid_busy_exec", {31'd0, busy}, 1);
        reset_n = 0;
        #1; chk("mid_busy_async", {31'd0, busy}, 0); chk("mid_resp_async", {31'd0, r0_resp_valid}, 0);
        nxt(); nxt();
        reset_n = 1; r1_valid = 1; r1_op = ALU_XOR; r1_a = 32'h1234; r1_b = 32'h00FF;
        mid(); chk("mid_r1_first_cycle", {31'd0, r1_ready}, 1);
        nxt(); r1_valid = 0;
        for (int i = 0; i < 5; i++) begin
            mid(); chk("mid_no_r0_resp", {31'd0, r0_resp_valid}, 0);
            nxt();
        end

        // Idle outputs.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("idle_alu_op", {28'd0, alu_op}, {28'd0, ALU_XXX});
            chk("idle_ready", {30'd0, r1_ready, r0_ready}, 0);
            chk("idle_busy", {31'd0, busy}, 0);
            nxt();
        end

        // Randomized traffic, with rare resets.
        n_done = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 0; nxt(); nxt(); reset_n = 1;
            end
            r0_valid = ($urandom_range(0, 1) == 1);
            r1_valid = ($urandom_range(0, 1) == 1);
            r0_op = ops[$urandom_range(0, 10)];
            r1_op = ops[$urandom_range(0, 10)];
            r0_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            r0_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            r1_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            r1_b = $urandom();
            r0_resp_ready = ($urandom_range(0, 9) < 6);
            r1_resp_ready = ($urandom_range(0, 9) < 6);
            nxt();
        end
        chk("random_progress", {31'd0, n_done > 200}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL equal the shared ALU data width (32).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 r0_valid / r1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 r0_ready / r1_ready  output  1  arbiter accepts requester 0/1 operation this cycle.
REQ-006 r0_a, r0_b / r1_a, r1_b  input  WIDTH  operands A and B of requester 0/1.
REQ-007 r0_op / r1_op  input  4  ALUop code (ALUop.vh encoding) of requester 0/1.
REQ-008 r0_resp_valid / r1_resp_valid  output  1  result available for requester 0/1.
REQ-009 r0_resp_data / r1_resp_data  output  WIDTH  result for requester 0/1.
REQ-010 r0_resp_ready / r1_resp_ready  input  1  requester 0/1 consumes its result.
REQ-011 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-012 alu_op  output  4  ALUop driven to the shared ALU.
REQ-013 alu_out  input  WIDTH  combinational result from the shared ALU.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, RESP, and nothing else.
REQ-016 IDLE: if any rX_valid, grant one requester, assert its rX_ready combinationally, latch its a/b/op into operand registers, record grant, go to EXEC; else stay.
REQ-017 Grant SHALL be: only one valid -> that one; both valid -> the requester selected by the priority pointer.
REQ-018 rX_ready SHALL be high only in IDLE, only for the granted requester; never both high together.
REQ-019 EXEC: alu_a/alu_b SHALL be the operand registers and alu_op the latched op; alu_out SHALL be captured into the result register; go to RESP.
REQ-020 Outside EXEC, alu_op SHALL be the ALU_XXX code; alu_a/alu_b SHALL keep showing the operand registers.
REQ-021 RESP: rG_resp_valid SHALL be high for the granted requester only; rG_resp_data SHALL equal the result register; both SHALL stay stable until rG_resp_ready is high.
REQ-022 On rG_resp_valid && rG_resp_ready: go to IDLE, set priority pointer to the non-granted requester.
REQ-023 Non-granted rX_resp_data SHALL read 0; the other requester's ready SHALL stay 0 through EXEC and RESP regardless of its valid.
REQ-024 Latency: accept edge -> resp_valid high 2 cycles later; min issue interval 3 cycles with resp_ready held high.
REQ-025 The arbiter SHALL not alter operands or results; arithmetic is solely the ALU's.
REQ-026 A request deasserted before acceptance SHALL be dropped without effect; once accepted it SHALL complete.

Reset
REQ-027 reset_n low SHALL immediately (asynchronously) force state IDLE, priority pointer 0, operand/op/result/grant registers 0, all resp_valid 0, busy 0.
REQ-028 Reset asserted in EXEC or RESP SHALL abandon the operation; no response SHALL be delivered after reset release.
REQ-029 After release, first acceptance SHALL be possible in the first clock cycle with a valid request.

Verification
REQ-030 Single op: r0 ADD a=5 b=7, r0_resp_ready=1 -> r0_ready 1 in cycle 0, r0_resp_valid in cycle 2 with data 12, busy 0 in cycle 3.
REQ-031 Contention: r0 SUB 10,3 and r1 XOR 0xF0,0xFF both valid after reset -> r0 served first (data 7), then r1 (data 0x0F); r1_ready 0 until IDLE returns.
REQ-032 Fairness: both valid continuously, resp_ready=1, 4 transactions -> grant order 0,1,0,1.
REQ-033 Backpressure: r1 SLT a=0xFFFFFFFF b=1, r1_resp_ready low 4 cycles -> r1_resp_valid=1, data=1 stable 4 cycles; r0 held off; then SLTU same operands -> 0.
REQ-034 Reset mid-op: reset_n low during EXEC of r0 ADD 1,1 -> resp_valid 0, busy 0 immediately; after release no r0 response appears; next r1 request accepted first cycle.
REQ-035 Idle outputs: no valid for 10 cycles -> alu_op = ALU_XXX, both ready 0, busy 0.
